// File: rtl/parse_context_pkt_if.sv
// parse_context_pkt_if: framed word input and parsed-context result port of parse_context_pkt
interface parse_context_pkt_if;
  logic [35:0] data_i;
  logic        src_rdy_i;
  logic        dst_rdy_o;
  logic        ctxt_valid;
  logic        ctxt_ready;
  logic [31:0] streamid;
  logic [63:0] vita_time;
  logic [31:0] message;
  logic [31:0] seqnum;
  logic [3:0]  hdr_seqno;
  logic        seq_err;
  logic        fmt_err;
  logic [15:0] err_count;
  modport slave (
    input  data_i, src_rdy_i, ctxt_ready,
    output dst_rdy_o, ctxt_valid, streamid, vita_time, message, seqnum,
           hdr_seqno, seq_err, fmt_err, err_count
  );
  modport master (
    output data_i, src_rdy_i, ctxt_ready,
    input  dst_rdy_o, ctxt_valid, streamid, vita_time, message, seqnum,
           hdr_seqno, seq_err, fmt_err, err_count
  );
endinterface

// File: rtl/parse_context_pkt.sv
// parse_context_pkt: parses framed VITA context packets into stream/time/message/seqnum results
module parse_context_pkt #(
  parameter bit PROT_ENG_FLAGS = 1'b1
) (
  input logic clk,
  input logic reset,
  input logic clear,
  parse_context_pkt_if.slave bus
);
  typedef enum logic [3:0] {IDLE, PROT_ENG, HEADER, STREAMID, TICS, TICS2, MESSAGE, FLOWCTRL, DRAIN} state_t;
  state_t r_state, w_next;
  logic [31:0] r_sh_sid, r_sh_hi, r_sh_lo, r_sh_msg;
  logic [3:0]  r_sh_seq;
  logic [31:0] r_streamid, r_message, r_seqnum;
  logic [63:0] r_vita_time;
  logic [3:0]  r_hdr_seqno;
  logic        r_valid, r_armed, r_fmt_err, r_seq_err;
  logic [15:0] r_err_count;
  logic [31:0] w_d;
  logic        w_sof, w_eof, w_acc, w_mid, w_pe_ok, w_hdr_ok, w_first_ok;
  logic        w_fmt, w_hdr_ld, w_deliver, w_seq, w_unused;
  assign w_d        = bus.data_i[31:0];
  assign w_sof      = bus.data_i[32];
  assign w_eof      = bus.data_i[33];
  assign w_unused   = ^bus.data_i[35:34];
  assign w_mid      = r_state != IDLE && r_state != DRAIN;
  assign w_pe_ok    = w_d[15:0] == 16'd24;
  assign w_hdr_ok   = w_d[31:28] == 4'h5 && w_d[15:0] == 16'd6;
  assign w_first_ok = PROT_ENG_FLAGS ? w_pe_ok : w_hdr_ok;
  // Only a finished packet waiting behind an unconsumed result can stall the input
  assign bus.dst_rdy_o = !(r_state == FLOWCTRL && r_valid && !bus.ctxt_ready);
  assign w_acc = bus.src_rdy_i & bus.dst_rdy_o;
  assign w_seq = w_deliver && r_armed && (r_sh_seq != r_hdr_seqno + 4'd1);
  always_comb begin
    w_next    = r_state;
    w_fmt     = 1'b0;
    w_hdr_ld  = 1'b0;
    w_deliver = 1'b0;
    if (w_acc && w_sof) begin
      w_fmt    = w_mid || !w_first_ok || w_eof;
      w_hdr_ld = !PROT_ENG_FLAGS;
      w_next   = w_eof ? IDLE : !w_first_ok ? DRAIN : PROT_ENG_FLAGS ? HEADER : STREAMID;
    end else if (w_acc) begin
      case (r_state)
        IDLE:  w_next = IDLE;
        DRAIN: w_next = w_eof ? IDLE : DRAIN;
        HEADER: begin
          w_hdr_ld = 1'b1;
          w_fmt    = w_eof || !w_hdr_ok;
          w_next   = w_eof ? IDLE : w_hdr_ok ? STREAMID : DRAIN;
        end
        FLOWCTRL: begin
          w_fmt     = !w_eof;
          w_deliver = w_eof;
          w_next    = w_eof ? IDLE : DRAIN;
        end
        default: begin
          w_fmt  = w_eof;
          w_next = w_eof ? IDLE : r_state == PROT_ENG ? HEADER : r_state == STREAMID ? TICS :
                   r_state == TICS ? TICS2 : r_state == TICS2 ? MESSAGE : FLOWCTRL;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_state     <= IDLE;
      r_valid     <= 1'b0;
      r_armed     <= 1'b0;
      r_fmt_err   <= 1'b0;
      r_seq_err   <= 1'b0;
      r_sh_sid    <= '0;
      r_sh_hi     <= '0;
      r_sh_lo     <= '0;
      r_sh_msg    <= '0;
      r_sh_seq    <= '0;
      r_streamid  <= '0;
      r_vita_time <= '0;
      r_message   <= '0;
      r_seqnum    <= '0;
      r_hdr_seqno <= '0;
    end else begin
      r_state   <= w_next;
      r_fmt_err <= w_fmt;
      r_seq_err <= w_seq;
      if (w_acc && r_state == STREAMID) r_sh_sid <= w_d;
      if (w_acc && r_state == TICS) r_sh_hi <= w_d;
      if (w_acc && r_state == TICS2) r_sh_lo <= w_d;
      if (w_acc && r_state == MESSAGE) r_sh_msg <= w_d;
      if (w_hdr_ld) r_sh_seq <= w_d[19:16];
      if (w_deliver) begin
        r_streamid  <= r_sh_sid;
        r_vita_time <= {r_sh_hi, r_sh_lo};
        r_message   <= r_sh_msg;
        r_seqnum    <= w_d;
        r_hdr_seqno <= r_sh_seq;
        r_valid     <= 1'b1;
        r_armed     <= 1'b1;
      end else if (bus.ctxt_ready) begin
        r_valid <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) r_err_count <= '0;
    else if (!clear && (w_fmt || w_seq) && r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
  end
  assign bus.ctxt_valid = r_valid;
  assign bus.streamid   = r_streamid;
  assign bus.vita_time  = r_vita_time;
  assign bus.message    = r_message;
  assign bus.seqnum     = r_seqnum;
  assign bus.hdr_seqno  = r_hdr_seqno;
  assign bus.seq_err    = r_seq_err;
  assign bus.fmt_err    = r_fmt_err;
  assign bus.err_count  = r_err_count;
endmodule

// File: tb/tb_parse_context_pkt.sv
// tb_parse_context_pkt: directed and randomized packet stream checked against a packet-level scoreboard
module tb_parse_context_pkt;
  typedef struct {
    logic [31:0] sid;
    logic [63:0] t;
    logic [31:0] msg;
    logic [31:0] fc;
    logic [3:0]  hdr;
  } res_t;
  logic clk = 1'b0, reset = 1'b1, clear = 1'b0;
  parse_context_pkt_if bus();
  parse_context_pkt #(.PROT_ENG_FLAGS(1'b1)) dut (.clk(clk), .reset(reset), .clear(clear), .bus(bus));
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  int n_fmt = 0, n_seq = 0, exp_fmt = 0, exp_seq = 0, exp_err = 0;
  bit armed = 1'b0, rnd = 1'b0;
  logic [3:0] prev = '0;
  logic [35:0] pk [7];
  res_t q[$];
  res_t mon_e;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic res_t rnd_res();
    res_t r;
    r.sid = $urandom;
    r.t   = {$urandom, $urandom};
    r.msg = $urandom;
    r.fc  = $urandom;
    r.hdr = ($urandom_range(0, 3) != 0) ? 4'(prev + 4'd1) : 4'($urandom);
    return r;
  endfunction
  function automatic void build(input res_t r);
    pk[0] = {2'($urandom), 2'b01, 16'($urandom), 16'd24};
    pk[1] = {4'b0000, 4'h5, 8'($urandom), r.hdr, 16'd6};
    pk[2] = {4'b0000, r.sid};
    pk[3] = {4'b0000, r.t[63:32]};
    pk[4] = {4'b0000, r.t[31:0]};
    pk[5] = {4'b0000, r.msg};
    pk[6] = {2'($urandom), 2'b10, r.fc};
  endfunction
  // Every delivered packet is compared against the header sequence of the one before it
  function automatic void deliver(input res_t r);
    if (armed && r.hdr != 4'(prev + 4'd1)) begin
      exp_seq++;
      exp_err++;
    end
    prev  = r.hdr;
    armed = 1'b1;
    q.push_back(r);
  endfunction
  function automatic void bad();
    exp_fmt++;
    exp_err++;
  endfunction
  task automatic send(input logic [35:0] w);
    int n = 0;
    logic acc;
    if (rnd && $urandom_range(0, 3) == 0)
      repeat ($urandom_range(1, 2)) begin
        bus.src_rdy_i = 1'b0;
        bus.ctxt_ready = 1'($urandom);
        @(posedge clk); #1;
      end
    bus.data_i = w;
    bus.src_rdy_i = 1'b1;
    do begin
      @(negedge clk);
      acc = bus.dst_rdy_o;
      @(posedge clk); #1;
      if (rnd) bus.ctxt_ready = 1'($urandom);
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("send_timeout", 0, 1);
    bus.src_rdy_i = 1'b0;
  endtask
  task automatic send_range(input int a, input int b);
    for (int i = a; i <= b; i++) send(pk[i]);
  endtask
  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    armed = 1'b0;
    exp_err = 0;
    q.delete();
  endtask
  task automatic pulse_clear();
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    armed = 1'b0;
  endtask
  always @(negedge clk) begin
    if (bus.fmt_err) n_fmt++;
    if (bus.seq_err) n_seq++;
    if (bus.ctxt_valid && bus.ctxt_ready) begin
      if (q.size() == 0) chk("spurious_result", 1, 0);
      else begin
        mon_e = q.pop_front();
        chk("res_streamid", bus.streamid, mon_e.sid);
        chk("res_vita_time", bus.vita_time, mon_e.t);
        chk("res_message", bus.message, mon_e.msg);
        chk("res_seqnum", bus.seqnum, mon_e.fc);
        chk("res_hdr_seqno", bus.hdr_seqno, mon_e.hdr);
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    res_t r, a, b;
    int kind, k;
    bus.data_i = '0;
    bus.src_rdy_i = 1'b0;
    bus.ctxt_ready = 1'b1;
    pulse_reset();
    chk("rst_dst_rdy", bus.dst_rdy_o, 1);
    chk("rst_valid", bus.ctxt_valid, 0);
    chk("rst_streamid", bus.streamid, 0);
    chk("rst_vita_time", bus.vita_time, 0);
    chk("rst_seqnum", bus.seqnum, 0);
    chk("rst_err_count", bus.err_count, 0);
    chk("rst_fmt_seq", {bus.fmt_err, bus.seq_err}, 0);
    // basic packet and one-cycle result latency
    r = '{sid: 32'hDEADBEEF, t: 64'h1_00000002, msg: 32'hCAFE, fc: 32'h55, hdr: 4'd1};
    build(r);
    pk[0] = {4'b0001, 32'h0001_0018};
    pk[1] = {4'b0000, 32'h5001_0006};
    deliver(r);
    send_range(0, 5);
    bus.data_i = pk[6];
    bus.src_rdy_i = 1'b1;
    @(negedge clk);
    chk("t1_pre_valid", bus.ctxt_valid, 0);
    @(posedge clk); #1;
    bus.src_rdy_i = 1'b0;
    chk("t1_valid", bus.ctxt_valid, 1);
    chk("t1_streamid", bus.streamid, 32'hDEADBEEF);
    chk("t1_vita_time", bus.vita_time, 64'h1_00000002);
    chk("t1_message", bus.message, 32'hCAFE);
    chk("t1_seqnum", bus.seqnum, 32'h55);
    chk("t1_hdr_seqno", bus.hdr_seqno, 1);
    chk("t1_errs", {bus.fmt_err, bus.seq_err}, 0);
    // sequence discontinuity, then clear and wrap
    pulse_reset();
    r = rnd_res(); r.hdr = 4'd3; build(r); deliver(r); send_range(0, 6);
    chk("t2_seq_ok", bus.seq_err, 0);
    r = rnd_res(); r.hdr = 4'd5; build(r); deliver(r); send_range(0, 6);
    chk("t2_seq_err", bus.seq_err, 1);
    chk("t2_err_count", bus.err_count, exp_err);
    pulse_clear();
    chk("t2_clear_keeps_count", bus.err_count, 1);
    r = rnd_res(); r.hdr = 4'd15; build(r); deliver(r); send_range(0, 6);
    r = rnd_res(); r.hdr = 4'd0; build(r); deliver(r); send_range(0, 6);
    chk("t2_wrap_no_seq_err", bus.seq_err, 0);
    chk("t2_wrap_err_count", bus.err_count, 1);
    // backpressure on the flow-control word
    pulse_reset();
    bus.ctxt_ready = 1'b0;
    a = rnd_res(); a.hdr = 4'd2; build(a); deliver(a); send_range(0, 6);
    b = rnd_res(); b.hdr = 4'd3; build(b); deliver(b); send_range(0, 5);
    bus.data_i = pk[6];
    bus.src_rdy_i = 1'b1;
    @(negedge clk);
    chk("t3_stall1", bus.dst_rdy_o, 0);
    @(negedge clk);
    chk("t3_stall2", bus.dst_rdy_o, 0);
    chk("t3_hold_streamid", bus.streamid, a.sid);
    @(posedge clk); #1;
    bus.ctxt_ready = 1'b1;
    @(negedge clk);
    chk("t3_release", bus.dst_rdy_o, 1);
    @(posedge clk); #1;
    bus.src_rdy_i = 1'b0;
    bus.ctxt_ready = 1'b0;
    chk("t3_valid_kept", bus.ctxt_valid, 1);
    chk("t3_new_streamid", bus.streamid, b.sid);
    chk("t3_new_seqnum", bus.seqnum, b.fc);
    bus.ctxt_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // bad header length drains to EOF
    r = rnd_res(); build(r); pk[1][15:0] = 16'd7; bad(); send_range(0, 6);
    chk("t4_no_valid", bus.ctxt_valid, 0);
    chk("t4_err_count", bus.err_count, exp_err);
    r = rnd_res(); build(r); deliver(r); send_range(0, 6);
    chk("t4_next_valid", bus.ctxt_valid, 1);
    chk("t4_next_streamid", bus.streamid, r.sid);
    // early EOF on TICS, then SOF on MESSAGE restarting a packet
    r = rnd_res(); build(r); pk[3][33] = 1'b1; bad(); send_range(0, 3);
    chk("t5_early_eof", bus.fmt_err, 1);
    r = rnd_res(); build(r); send_range(0, 4);
    r = rnd_res(); build(r); deliver(r); bad(); send(pk[0]);
    chk("t5_mid_sof", bus.fmt_err, 1);
    send_range(1, 6);
    chk("t5_restart_streamid", bus.streamid, r.sid);
    chk("t5_err_count", bus.err_count, exp_err);
    // reset while the TICS word is expected
    r = rnd_res(); build(r); send_range(0, 2);
    pulse_reset();
    chk("t6_valid", bus.ctxt_valid, 0);
    chk("t6_streamid", bus.streamid, 0);
    chk("t6_vita_time", bus.vita_time, 0);
    chk("t6_msg_seq", {bus.message, bus.seqnum}, 0);
    chk("t6_hdr_seqno", bus.hdr_seqno, 0);
    chk("t6_err_count", bus.err_count, 0);
    r = rnd_res(); r.hdr = 4'd9; build(r); deliver(r); send_range(0, 6);
    chk("t6_no_seq_err", bus.seq_err, 0);
    chk("t6_streamid_new", bus.streamid, r.sid);
    // randomized traffic with protocol faults mixed in
    rnd = 1'b1;
    for (int p = 0; p < 400; p++) begin
      kind = $urandom_range(0, 9);
      r = rnd_res();
      build(r);
      if (kind <= 3) begin
        deliver(r); send_range(0, 6);
      end else if (kind == 4) begin
        k = $urandom_range(0, 2);
        if (k == 0) pk[1][15:0] = 16'd7;
        else if (k == 1) pk[1][31:28] = 4'h4;
        else pk[0][15:0] = 16'd23;
        bad(); send_range(0, 6);
      end else if (kind == 5) begin
        k = $urandom_range(0, 5);
        pk[k][33] = 1'b1;
        bad(); send_range(0, k);
      end else if (kind == 6) begin
        pk[6][33] = 1'b0;
        bad(); send_range(0, 6);
        send({2'b00, 2'b10, 32'($urandom)});
      end else if (kind == 7) begin
        k = $urandom_range(1, 6);
        send_range(0, k - 1);
        r = rnd_res(); build(r); deliver(r); bad(); send_range(0, 6);
      end else begin
        repeat ($urandom_range(1, 3)) send({2'($urandom), 1'($urandom), 1'b0, 32'($urandom)});
      end
    end
    rnd = 1'b0;
    bus.ctxt_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("final_queue_empty", q.size(), 0);
    chk("final_fmt_pulses", n_fmt, exp_fmt);
    chk("final_seq_pulses", n_seq, exp_seq);
    chk("final_err_count", bus.err_count, exp_err);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
